// File: rtl/jt12_mixer_if.sv
// jt12_mixer_if: sample inputs, register bus and mixed stereo outputs of the FM+PSG mixer.
interface jt12_mixer_if #(parameter int NUM_PSG = 3);
  logic signed [15:0]   fm_left, fm_right;
  logic [8*NUM_PSG-1:0] psg;
  logic                 sample, wr;
  logic [3:0]           waddr;
  logic [7:0]           wdata;
  logic [15:0]          left, right;
  logic                 out_valid, overrun, busy;
  modport master (output fm_left, fm_right, psg, sample, wr, waddr, wdata,
                  input left, right, out_valid, overrun, busy);
  modport slave (input fm_left, fm_right, psg, sample, wr, waddr, wdata,
                 output left, right, out_valid, overrun, busy);
endinterface

// File: rtl/jt12_mixer.sv
// jt12_mixer: serial gain/pan stereo mixer of FM plus NUM_PSG PSG channels, one source per cen cycle.
module jt12_mixer #(
  parameter int NUM_PSG   = 3,
  parameter int PSG_SHIFT = 5,
  parameter int ACC_W     = 20
) (
  input logic clk,
  input logic rst_n,
  input logic cen,
  jt12_mixer_if.slave bus
);
  localparam int IW = $clog2(NUM_PSG + 1);
  localparam int PW = 16 + PSG_SHIFT;
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-32768);
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic signed [15:0] fml_q, fml_d, fmr_q, fmr_d;
  logic [7:0] psg_q [NUM_PSG], psg_d [NUM_PSG];
  logic [7:0] gain_q [NUM_PSG+1], gain_d [NUM_PSG+1], gsh_q [NUM_PSG+1], gsh_d [NUM_PSG+1];
  logic [1:0] pan_q [NUM_PSG], pan_d [NUM_PSG], psh_q [NUM_PSG], psh_d [NUM_PSG];
  logic [15:0] left_q, left_d, right_q, right_d;
  logic out_valid_q, out_valid_d, overrun_q, overrun_d, busy_q, busy_d;
  logic [7:0] cur_gain, cur_psg;
  logic [1:0] cur_pan;
  logic signed [24:0] fml_prod, fmr_prod;
  logic [PW-1:0] psg_prod;
  logic signed [ACC_W-1:0] fml_term, fmr_term, psg_term, term_l, term_r;

  function automatic logic [15:0] sat(input logic signed [ACC_W-1:0] a);
    return a > MAX_V ? 16'h7fff : a < MIN_V ? 16'h8000 : a[15:0];
  endfunction

  // Single shared MAC per side: select the source addressed by idx from the shadow copies.
  always_comb begin
    cur_gain = gsh_q[0];
    cur_psg  = '0;
    cur_pan  = '0;
    for (int k = 1; k <= NUM_PSG; k++)
      if (idx_q == IW'(k)) begin
        cur_gain = gsh_q[k];
        cur_psg  = psg_q[k-1];
        cur_pan  = psh_q[k-1];
      end
    fml_prod = fml_q * $signed({1'b0, cur_gain});
    fmr_prod = fmr_q * $signed({1'b0, cur_gain});
    psg_prod = PW'({cur_psg, {PSG_SHIFT{1'b0}}}) * PW'(cur_gain);
    fml_term = ACC_W'(fml_prod >>> 7);
    fmr_term = ACC_W'(fmr_prod >>> 7);
    psg_term = $signed(ACC_W'(psg_prod >> 7));
    term_l   = idx_q == '0 ? fml_term : cur_pan[1] ? psg_term : '0;
    term_r   = idx_q == '0 ? fmr_term : cur_pan[0] ? psg_term : '0;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    fml_d       = fml_q;
    fmr_d       = fmr_q;
    psg_d       = psg_q;
    gain_d      = gain_q;
    gsh_d       = gsh_q;
    pan_d       = pan_q;
    psh_d       = psh_q;
    left_d      = left_q;
    right_d     = right_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    busy_d      = busy_q;
    for (int k = 0; k <= NUM_PSG; k++)
      if (bus.wr && bus.waddr == 4'(k)) gain_d[k] = bus.wdata;
    for (int k = 0; k < NUM_PSG; k++)
      if (bus.wr && bus.waddr == 4'(8 + k)) pan_d[k] = bus.wdata[1:0];
    if (bus.wr && bus.waddr == 4'd15 && bus.wdata[0]) overrun_d = 1'b0;
    if (cen) begin
      if (state_q == IDLE && bus.sample) begin
        fml_d   = bus.fm_left;
        fmr_d   = bus.fm_right;
        for (int k = 0; k < NUM_PSG; k++) psg_d[k] = bus.psg[8*k +: 8];
        gsh_d   = gain_q;
        psh_d   = pan_q;
        acc_l_d = '0;
        acc_r_d = '0;
        idx_d   = '0;
        busy_d  = 1'b1;
        state_d = ACC;
      end
      // Placed after the clear so a simultaneous overrun wins.
      if (state_q != IDLE && bus.sample) overrun_d = 1'b1;
      if (state_q == ACC) begin
        acc_l_d = acc_l_q + term_l;
        acc_r_d = acc_r_q + term_r;
        idx_d   = idx_q + 1'b1;
        state_d = idx_q == IW'(NUM_PSG) ? OUT : ACC;
      end
      if (state_q == OUT) begin
        left_d      = sat(acc_l_q);
        right_d     = sat(acc_r_q);
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      fml_q       <= '0;
      fmr_q       <= '0;
      psg_q       <= '{default: 8'h00};
      gain_q      <= '{default: 8'h80};
      gsh_q       <= '{default: 8'h80};
      pan_q       <= '{default: 2'b11};
      psh_q       <= '{default: 2'b11};
      left_q      <= '0;
      right_q     <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      fml_q       <= fml_d;
      fmr_q       <= fmr_d;
      psg_q       <= psg_d;
      gain_q      <= gain_d;
      gsh_q       <= gsh_d;
      pan_q       <= pan_d;
      psh_q       <= psh_d;
      left_q      <= left_d;
      right_q     <= right_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end

  assign bus.left      = left_q;
  assign bus.right     = right_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_jt12_mixer.sv
// tb_jt12_mixer: scoreboard bench; expected stereo results are queued at each strobe from a reference model.
module tb_jt12_mixer;
  logic clk = 1'b0, rst_n = 1'b0, cen = 1'b0;
  always #5 clk = ~clk;

  jt12_mixer_if #(.NUM_PSG(3)) bus();
  jt12_mixer #(.NUM_PSG(3), .PSG_SHIFT(5), .ACC_W(20)) dut (.clk(clk), .rst_n(rst_n), .cen(cen), .bus(bus));

  int errors = 0, checks = 0, duty = 1;
  logic last_ov, last_busy;
  logic [7:0] m_gain [4];
  logic [1:0] m_pan [3];
  logic [31:0] sb [$];
  logic [31:0] exp_q;

  // Reference model of one sample using the register values in force at the strobe.
  function automatic logic [31:0] model(input int fl, input int fr, input logic [23:0] p);
    int l, r, g, t;
    g = int'(m_gain[0]);
    l = (fl * g) >>> 7;
    r = (fr * g) >>> 7;
    for (int k = 0; k < 3; k++) begin
      t = (int'(p[8*k +: 8]) * 32 * int'(m_gain[k+1])) >>> 7;
      if (m_pan[k][1]) l += t;
      if (m_pan[k][0]) r += t;
    end
    l = l > 32767 ? 32767 : l < -32768 ? -32768 : l;
    r = r > 32767 ? 32767 : r < -32768 ? -32768 : r;
    return {l[15:0], r[15:0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_gain[k] = 8'h80;
    for (int k = 0; k < 3; k++) m_pan[k] = 2'b11;
  endtask

  task automatic cstep(input logic s);
    cen = 1'b1;
    bus.sample = s;
    @(posedge clk);
    #1;
    last_ov = bus.out_valid;
    last_busy = bus.busy;
    cen = 1'b0;
    bus.sample = 1'b0;
    repeat (duty - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wreg(input logic [3:0] a, input logic [7:0] d);
    bus.wr = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
    if (a <= 4'd3) m_gain[a[1:0]] = d;
    else if (a >= 4'd8 && a <= 4'd10) m_pan[2'(a - 4'd8)] = d[1:0];
  endtask

  task automatic strobe(input int fl, input int fr, input logic [23:0] p, input bit push);
    bus.fm_left = 16'(fl);
    bus.fm_right = 16'(fr);
    bus.psg = p;
    if (push) sb.push_back(model(fl, fr, p));
    cstep(1'b1);
    bus.fm_left = ~bus.fm_left;
    bus.fm_right = ~bus.fm_right;
    bus.psg = ~p;
  endtask

  task automatic wait_out(input int lat, input bit chk_busy);
    int n = 0;
    do begin
      cstep(1'b0);
      n++;
      if (chk_busy) begin
        checks++;
        if (last_busy !== !last_ov) begin
          errors++;
          $display("FAIL busy step %0d: got %b want %b", n, last_busy, !last_ov);
        end
      end
    end while (!last_ov && n < 20);
    checks++;
    if (!last_ov || n != lat) begin
      errors++;
      $display("FAIL latency: got %0d cen steps (valid=%b), want %0d", n, last_ov, lat);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && bus.out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: unexpected out_valid left=%0d right=%0d", $signed(bus.left), $signed(bus.right));
      end else begin
        exp_q = sb.pop_front();
        if (bus.left !== exp_q[31:16] || bus.right !== exp_q[15:0]) begin
          errors++;
          $display("FAIL scoreboard: got left=%0d right=%0d want left=%0d right=%0d",
                   $signed(bus.left), $signed(bus.right), $signed(exp_q[31:16]), $signed(exp_q[15:0]));
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.left !== 16'd0 || bus.right !== 16'd0 || bus.out_valid !== 1'b0 || bus.overrun !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: got l=%0d r=%0d v=%b o=%b b=%b want all 0", bus.left, bus.right, bus.out_valid, bus.overrun, bus.busy);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    strobe(1000, -1000, 24'h0, 1'b1);
    checks++;
    if (last_busy !== 1'b1) begin errors++; $display("FAIL busy at capture: got %b want 1", last_busy); end
    wait_out(5, 1'b1);
    checks++;
    if (bus.left !== 16'(1000) || bus.right !== 16'(-1000)) begin
      errors++;
      $display("FAIL basic fm: got %0d/%0d want 1000/-1000", $signed(bus.left), $signed(bus.right));
    end
  endtask

  task automatic test_pan();
    wreg(4'd1, 8'h40);
    wreg(4'd8, 8'h02);
    strobe(0, 0, 24'h000064, 1'b1);
    wait_out(5, 1'b0);
    checks++;
    if (bus.left !== 16'd1600 || bus.right !== 16'd0) begin
      errors++;
      $display("FAIL pan left: got %0d/%0d want 1600/0", $signed(bus.left), $signed(bus.right));
    end
    wreg(4'd8, 8'hFD);
    strobe(0, 0, 24'h000064, 1'b1);
    wait_out(5, 1'b0);
    checks++;
    if (bus.left !== 16'd0 || bus.right !== 16'd1600) begin
      errors++;
      $display("FAIL pan right: got %0d/%0d want 0/1600", $signed(bus.left), $signed(bus.right));
    end
    wreg(4'd1, 8'h80);
    wreg(4'd8, 8'h03);
  endtask

  task automatic test_sat();
    wreg(4'd0, 8'hFF);
    strobe(32767, -32768, 24'h0, 1'b1);
    wait_out(5, 1'b0);
    checks++;
    if (bus.left !== 16'h7fff || bus.right !== 16'h8000) begin
      errors++;
      $display("FAIL saturation: got %0d/%0d want 32767/-32768", $signed(bus.left), $signed(bus.right));
    end
  endtask

  task automatic test_shadow();
    wreg(4'd0, 8'h80);
    strobe(1234, -77, 24'h0, 1'b1);
    cstep(1'b0);
    wreg(4'd0, 8'h00);
    wait_out(4, 1'b0);
    checks++;
    if (bus.left !== 16'(1234) || bus.right !== 16'(-77)) begin
      errors++;
      $display("FAIL shadow N: got %0d/%0d want 1234/-77", $signed(bus.left), $signed(bus.right));
    end
    strobe(1234, -77, 24'h0, 1'b1);
    wait_out(5, 1'b0);
    checks++;
    if (bus.left !== 16'd0 || bus.right !== 16'd0) begin
      errors++;
      $display("FAIL shadow N+1: got %0d/%0d want 0/0", $signed(bus.left), $signed(bus.right));
    end
    wreg(4'd0, 8'h80);
  endtask

  task automatic test_overrun();
    int extra = 0;
    strobe(300, 400, 24'h0, 1'b1);
    cstep(1'b0);
    strobe(-5000, 5000, 24'hFFFFFF, 1'b0);
    wait_out(3, 1'b0);
    repeat (8) begin
      cstep(1'b0);
      if (last_ov) extra++;
    end
    checks++;
    if (extra != 0 || bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun sticky: got extra=%0d overrun=%b want 0/1", extra, bus.overrun);
    end
    wreg(4'd15, 8'h01);
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun clear: got %b want 0", bus.overrun); end
    strobe(-20, 20, 24'h0, 1'b1);
    cstep(1'b0);
    cen = 1'b1; bus.sample = 1'b1; bus.wr = 1'b1; bus.waddr = 4'd15; bus.wdata = 8'h01;
    @(posedge clk);
    #1;
    cen = 1'b0; bus.sample = 1'b0; bus.wr = 1'b0;
    checks++;
    if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun set wins: got %b want 1", bus.overrun); end
    wait_out(3, 1'b0);
    wreg(4'd15, 8'h01);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      for (int a = 0; a < 4; a++) wreg(4'(a), 8'($urandom));
      for (int a = 8; a < 11; a++) wreg(4'(a), 8'($urandom));
      strobe(int'($signed(16'($urandom))), int'($signed(16'($urandom))), 24'($urandom), 1'b1);
      wait_out(5, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int extra = 0;
    strobe(11, 22, 24'h0, 1'b0);
    cstep(1'b0);
    cstep(1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.left !== 16'd0 || bus.right !== 16'd0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid reset: got l=%0d r=%0d b=%b v=%b want 0", bus.left, bus.right, bus.busy, bus.out_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (8) begin
      cstep(1'b0);
      if (last_ov) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL mid reset valid: got %0d pulses want 0", extra); end
    strobe(500, -300, 24'h102030, 1'b1);
    wait_out(5, 1'b1);
  endtask

  task automatic test_duty();
    duty = 3;
    strobe(1000, -1000, 24'h0, 1'b1);
    wait_out(5, 1'b1);
    checks++;
    if (bus.left !== 16'(1000) || bus.right !== 16'(-1000)) begin
      errors++;
      $display("FAIL duty: got %0d/%0d want 1000/-1000", $signed(bus.left), $signed(bus.right));
    end
    duty = 1;
  endtask

  initial begin
    bus.fm_left = '0; bus.fm_right = '0; bus.psg = '0;
    bus.sample = 1'b0; bus.wr = 1'b0; bus.waddr = '0; bus.wdata = '0;
    test_reset();
    test_pan();
    test_sat();
    test_shadow();
    test_overrun();
    test_random();
    test_reset_mid();
    test_duty();
    repeat (4) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard drain: got %0d pending want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/jt12_mixer.md
Name: jt12_mixer

Overview:
- Parametrised stereo mixer for the FM+PSG sound path, superseding the fixed FM+PSG adders.
- On each sample strobe it captures FM left/right and NUM_PSG unsigned PSG channels.
- Applies a per-source gain and a per-PSG-channel pan, then accumulates serially, one source per cen cycle, with a single MAC per side.
- Outputs saturated 16-bit stereo with a valid pulse. Sits between the synthesis core and the board audio DAC/I2S.

Parameters:
- NUM_PSG, 3, number of PSG channels mixed (1..6).
- PSG_SHIFT, 5, left shift applied to each 8-bit PSG sample before gain.
- ACC_W, 20, signed accumulator width (must be >= 16 + ceil(log2(NUM_PSG+2)) + 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; every sequential step except register writes is qualified by cen
- fm_left  in  16  signed FM left sample
- fm_right  in  16  signed FM right sample
- psg  in  8*NUM_PSG  unsigned PSG channels, channel k at [8k+7:8k]
- sample  in  1  sample strobe (one cen cycle wide)
- wr  in  1  register write strobe (clk domain, not cen-qualified)
- waddr  in  4  register index
- wdata  in  8  register write data
- left  out  16  signed mixed left
- right  out  16  signed mixed right
- out_valid  out  1  one-clk pulse when left/right update
- overrun  out  1  sticky: a sample strobe arrived while busy
- busy  out  1  high from capture until output

Behaviour:
- Register map:
  - 0 = FM gain.
  - 1..NUM_PSG = PSG channel (idx-1) gain.
  - 8..8+NUM_PSG-1 = pan for PSG channel (idx-8); bit1 = L enable, bit0 = R enable, bits[7:2] ignored.
  - 15 = control; writing with wdata[0]=1 clears overrun.
  - Writes to other indices are ignored.
- Gains are unsigned Q1.7: 0x80 = 1.0, 0xFF ≈ 1.99, 0x00 = mute.
- Reset values: all gains 0x80; all pans 2'b11; left = right = 0; out_valid = 0; overrun = 0; busy = 0; state IDLE.
- Register writes update the live register file immediately. A shadow copy is loaded at capture; the current computation uses only the shadow, so writes apply from the next sample.
- FSM:
  - IDLE: on cen & sample, latch fm_left, fm_right and psg; load shadows; clear both accumulators; idx = 0; go to ACC; busy = 1.
  - ACC, one source per cen cycle:
    - idx 0: accL += (fm_left*gain0)>>>7 and accR += (fm_right*gain0)>>>7.
    - idx k (1..NUM_PSG): term = (({psg_k,PSG_SHIFT zeros}) * gain_k)>>7; added to accL if pan L, to accR if pan R.
    - At idx = NUM_PSG go to OUT.
  - OUT: saturate each accumulator to [-32768, 32767]; register left/right; out_valid = 1 for exactly one clk; busy = 0; go to IDLE.
- Latency: out_valid is asserted on the cen cycle NUM_PSG+2 after the capturing strobe (5 for the default).
- Arithmetic: products are full width (signed 16 × unsigned 8 → 25 bits signed). The arithmetic shift right floors toward -inf. Terms are sign-extended to ACC_W. No intermediate wrap is allowed.
- Strobe while busy (ACC or OUT): strobe ignored, inputs not recaptured, overrun set. Strobe on the OUT cycle also counts as busy.
- Simultaneous overrun set and control clear in the same clk: set wins.
- cen low: FSM holds; out_valid stays 0 unless the OUT step executes with cen high.
- rst_n asserted mid-operation: immediate return to reset values. The partial sample is discarded and no out_valid is produced.
- left/right hold their last value between out_valid pulses.

Test Plan:
- Reset defaults, fm_left = 1000, fm_right = -1000, psg all 0, one strobe -> exactly one out_valid 5 cen cycles later; left = 1000, right = -1000; busy high for cycles 0..4.
- PSG channel 0 = 100, its gain set to 0x40, pan 2'b10, FM = 0 -> left = 1600, right = 0. Then pan 2'b01 -> left = 0, right = 1600.
- fm_left = 32767, fm_right = -32768, FM gain 0xFF -> left = 32767, right = -32768 (saturated, no wrap).
- FM gain changed 0x80 -> 0x00 during ACC of sample N -> sample N uses 0x80 (left = fm_left); sample N+1 left = 0.
- Second strobe 2 cen cycles after the first -> single out_valid, overrun = 1 and held. Write reg 15 = 0x01 -> overrun = 0. Clear concurrent with a new overrun -> overrun = 1.
- rst_n pulsed low during ACC -> outputs 0, no out_valid, next strobe produces a correct result after 5 cen cycles. Also repeat the first test with cen at a 1-in-3 duty -> identical values, latency scales to 5 cen cycles.
